// File: rtl/lsu_dbus_if.sv
// Bundle of the LSU pipeline request/response and the dbus request/completion signals.
// The master modport is the LSU side; the slave modport is the pipeline plus the data cache.
interface lsu_dbus_if #(
  parameter int TAG_WIDTH = 5
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic                 req_uncache;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 flush;
  logic                 dbus_valid;
  logic                 dbus_op;
  logic                 dbus_uncache;
  logic [31:0]          dbus_address;
  logic [1:0]           dbus_size;
  logic [3:0]           dbus_wstrb;
  logic [31:0]          dbus_wdata;
  logic                 dbus_addr_ok;
  logic                 dbus_data_ok;
  logic [31:0]          dbus_rdata;
  logic                 resp_valid;
  logic                 resp_op;
  logic                 resp_exc;
  logic [31:0]          resp_rdata;
  logic [TAG_WIDTH-1:0] resp_tag;

  modport master (
    input  req_valid, req_op, req_size, req_signed, req_uncache, req_addr, req_wdata, req_tag,
    input  flush, dbus_addr_ok, dbus_data_ok, dbus_rdata,
    output req_ready, dbus_valid, dbus_op, dbus_uncache, dbus_address, dbus_size,
    output dbus_wstrb, dbus_wdata, resp_valid, resp_op, resp_exc, resp_rdata, resp_tag
  );

  modport slave (
    output req_valid, req_op, req_size, req_signed, req_uncache, req_addr, req_wdata, req_tag,
    output flush, dbus_addr_ok, dbus_data_ok, dbus_rdata,
    input  req_ready, dbus_valid, dbus_op, dbus_uncache, dbus_address, dbus_size,
    input  dbus_wstrb, dbus_wdata, resp_valid, resp_op, resp_exc, resp_rdata, resp_tag
  );
endinterface

// File: rtl/lsu_dbus_master.sv
// LSU data-bus initiator: single hold register feeding dbus, in-order tracking queue of
// accepted requests, load data extension, local misalignment exceptions and flush handling.
module lsu_dbus_master #(
  parameter int OUTSTANDING = 2,
  parameter int TAG_WIDTH   = 5
) (
  input logic        clk,
  input logic        resetn,
  lsu_dbus_if.master bus
);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1) + 1;
  localparam logic [CW-1:0] OUT_MAX  = CW'(OUTSTANDING);
  localparam logic [PW-1:0] LAST_IDX = PW'(OUTSTANDING - 1);

  logic                 hold_valid_reg, hold_op_reg, hold_signed_reg, hold_uncache_reg;
  logic [1:0]           hold_size_reg;
  logic [31:0]          hold_addr_reg, hold_wdata_reg;
  logic [3:0]           hold_wstrb_reg;
  logic [TAG_WIDTH-1:0] hold_tag_reg;

  logic                 q_op_reg     [OUTSTANDING];
  logic                 q_signed_reg [OUTSTANDING];
  logic                 q_drop_reg   [OUTSTANDING];
  logic [1:0]           q_size_reg   [OUTSTANDING];
  logic [1:0]           q_off_reg    [OUTSTANDING];
  logic [TAG_WIDTH-1:0] q_tag_reg    [OUTSTANDING];
  logic [PW-1:0]        head_reg, tail_reg;
  logic [CW-1:0]        count_reg;

  logic                 resp_valid_reg, resp_op_reg, resp_exc_reg;
  logic [31:0]          resp_rdata_reg;
  logic [TAG_WIDTH-1:0] resp_tag_reg;

  logic [1:0]    size_n;
  logic          misaligned, accept, pop, hold_free, room, ready, fire, load_hold;
  logic [CW-1:0] occ, q_after;
  logic [3:0]    fmt_wstrb;
  logic [31:0]   fmt_wdata, shifted, ext;

  assign size_n = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;

  always_comb begin
    case (size_n)
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign accept    = hold_valid_reg && bus.dbus_addr_ok;
  assign pop       = bus.dbus_data_ok && (count_reg != '0);
  assign occ       = count_reg + CW'(hold_valid_reg);
  assign q_after   = count_reg + CW'(1) - CW'(pop);
  // The hold register can only take a new op when it is empty or being handed off this cycle.
  assign hold_free = !hold_valid_reg || accept;
  assign room      = hold_free && ((occ < OUT_MAX) || (accept && (q_after < OUT_MAX)));
  assign ready     = !bus.flush && (misaligned ? (occ == '0) : room);
  assign fire      = bus.req_valid && ready;
  assign load_hold = fire && !misaligned;

  always_comb begin
    fmt_wstrb = 4'h0;
    fmt_wdata = bus.req_wdata;
    if (bus.req_op) begin
      case (size_n)
        2'd0: begin
          fmt_wstrb = 4'b0001 << bus.req_addr[1:0];
          fmt_wdata = {4{bus.req_wdata[7:0]}};
        end
        2'd1: begin
          fmt_wstrb = 4'b0011 << bus.req_addr[1:0];
          fmt_wdata = {2{bus.req_wdata[15:0]}};
        end
        default: fmt_wstrb = 4'hF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_valid_reg   <= 1'b0;
      hold_op_reg      <= 1'b0;
      hold_signed_reg  <= 1'b0;
      hold_uncache_reg <= 1'b0;
      hold_size_reg    <= 2'd0;
      hold_addr_reg    <= 32'd0;
      hold_wdata_reg   <= 32'd0;
      hold_wstrb_reg   <= 4'd0;
      hold_tag_reg     <= '0;
    end else if (load_hold) begin
      hold_valid_reg   <= 1'b1;
      hold_op_reg      <= bus.req_op;
      hold_signed_reg  <= bus.req_signed;
      hold_uncache_reg <= bus.req_uncache;
      hold_size_reg    <= size_n;
      hold_addr_reg    <= bus.req_addr;
      hold_wdata_reg   <= fmt_wdata;
      hold_wstrb_reg   <= fmt_wstrb;
      hold_tag_reg     <= bus.req_tag;
    end else if (accept || bus.flush) begin
      hold_valid_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (accept) tail_reg <= (tail_reg == LAST_IDX) ? '0 : tail_reg + 1'b1;
      if (pop)    head_reg <= (head_reg == LAST_IDX) ? '0 : head_reg + 1'b1;
      count_reg <= count_reg + CW'(accept) - CW'(pop);
    end
  end

  // A request handed off during the flush cycle enters the queue already dropped.
  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!resetn) begin
        q_op_reg[gi]     <= 1'b0;
        q_signed_reg[gi] <= 1'b0;
        q_drop_reg[gi]   <= 1'b0;
        q_size_reg[gi]   <= 2'd0;
        q_off_reg[gi]    <= 2'd0;
        q_tag_reg[gi]    <= '0;
      end else if (accept && (tail_reg == PW'(gi))) begin
        q_op_reg[gi]     <= hold_op_reg;
        q_signed_reg[gi] <= hold_signed_reg;
        q_drop_reg[gi]   <= bus.flush;
        q_size_reg[gi]   <= hold_size_reg;
        q_off_reg[gi]    <= hold_addr_reg[1:0];
        q_tag_reg[gi]    <= hold_tag_reg;
      end else if (bus.flush) begin
        q_drop_reg[gi]   <= 1'b1;
      end
    end
  end

  assign shifted = bus.dbus_rdata >> {q_off_reg[head_reg], 3'b000};

  always_comb begin
    case (q_size_reg[head_reg])
      2'd0:    ext = {{24{q_signed_reg[head_reg] & shifted[7]}}, shifted[7:0]};
      2'd1:    ext = {{16{q_signed_reg[head_reg] & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid_reg <= 1'b0;
      resp_op_reg    <= 1'b0;
      resp_exc_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_tag_reg   <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_op_reg    <= 1'b0;
      resp_exc_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_tag_reg   <= '0;
      if (pop && !q_drop_reg[head_reg]) begin
        resp_valid_reg <= 1'b1;
        resp_op_reg    <= q_op_reg[head_reg];
        resp_rdata_reg <= q_op_reg[head_reg] ? 32'd0 : ext;
        resp_tag_reg   <= q_tag_reg[head_reg];
      end else if (fire && misaligned) begin
        resp_valid_reg <= 1'b1;
        resp_op_reg    <= bus.req_op;
        resp_exc_reg   <= 1'b1;
        resp_tag_reg   <= bus.req_tag;
      end
    end
  end

  assign bus.req_ready    = ready;
  assign bus.dbus_valid   = hold_valid_reg;
  assign bus.dbus_op      = hold_op_reg;
  assign bus.dbus_uncache = hold_uncache_reg;
  assign bus.dbus_address = hold_addr_reg;
  assign bus.dbus_size    = hold_size_reg;
  assign bus.dbus_wstrb   = hold_wstrb_reg;
  assign bus.dbus_wdata   = hold_wdata_reg;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_op      = resp_op_reg;
  assign bus.resp_exc     = resp_exc_reg;
  assign bus.resp_rdata   = resp_rdata_reg;
  assign bus.resp_tag     = resp_tag_reg;
endmodule

// File: doc/lsu_dbus_master.md
Name: lsu_dbus_master

Overview:
- CPU-side initiator (master end) of the data bus that the data cache serves.
- Accepts load/store micro-ops from the memory pipeline stage and drives the dbus request. It aligns store data and byte strobes, and tracks up to OUTSTANDING in-flight requests in order.
- Returns aligned, sign- or zero-extended load data tagged with the destination register.
- Detects misaligned accesses locally and flushes queued and in-flight requests on pipeline cancel.

Parameters:
- OUTSTANDING, 2: maximum requests accepted on dbus whose data_ok has not yet returned (power of 2, ≥1).
- TAG_WIDTH, 5: width of the destination tag carried with each request.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline offers a memory op.
- req_ready  out  1  op is taken this cycle when req_valid && req_ready.
- req_op  in  1  0 = load, 1 = store.
- req_size  in  2  0 = byte, 1 = half, 2 = word (3 is illegal and treated as word).
- req_signed  in  1  loads: sign-extend.
- req_uncache  in  1  uncached access.
- req_addr  in  32  byte address.
- req_wdata  in  32  unaligned store value (LSBs significant).
- req_tag  in  TAG_WIDTH  destination tag.
- flush  in  1  cancel everything not yet returned.
- dbus_valid  out  1  request valid.
- dbus_op  out  1  request direction.
- dbus_uncache  out  1  request uncached.
- dbus_address  out  32  request address.
- dbus_size  out  2  request size.
- dbus_wstrb  out  4  request byte strobes.
- dbus_wdata  out  32  request write data.
- dbus_addr_ok  in  1  request accepted when dbus_valid && dbus_addr_ok.
- dbus_data_ok  in  1  oldest accepted request completed.
- dbus_rdata  in  32  load data, valid with data_ok.
- resp_valid  out  1  one-cycle completion pulse.
- resp_op  out  1  direction of completed op.
- resp_exc  out  1  misaligned-address exception.
- resp_rdata  out  32  extended load data (0 for stores and exceptions).
- resp_tag  out  TAG_WIDTH  tag of completed op.

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - hold register empty, outstanding queue empty, drop counter 0.
  - all outputs 0: dbus_valid, dbus_wstrb, dbus_address, resp_valid, resp_exc, resp_rdata, resp_tag.
  - Reset mid-transaction abandons in-flight entries. Any data_ok arriving after reset is ignored while the queue is empty.
- Hold register (single entry):
  - Drives the dbus_* outputs. dbus_valid = hold_valid.
  - Once dbus_valid rises, the dbus fields stay stable until accepted; they are never withdrawn except by flush.
- Occupancy:
  - occ = queue_count + hold_valid.
  - req_ready = !flush && (occ < OUTSTANDING || (hold accepted this cycle && queue not full after the data_ok pop)).
- Alignment:
  - Half with addr[0] ≠ 0, or word with addr[1:0] ≠ 0, is misaligned.
  - A misaligned op is accepted only when occ == 0. It never reaches dbus.
  - Next cycle: resp_valid = 1, resp_exc = 1, resp_rdata = 0, resp_tag = req_tag.
- Store formatting (aligned, o = addr[1:0]):
  - Byte: wstrb = 4'b0001 << o; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011 << o; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'hF.
  - Loads: wstrb = 0.
- Acceptance (dbus_valid && dbus_addr_ok):
  - Push {op, size, signed, addr[1:0], tag, dropped = 0} into an in-order queue of depth OUTSTANDING.
  - The hold register is freed and may reload in the same cycle.
- Completion (dbus_data_ok with queue non-empty):
  - Pop the queue head. Next cycle resp_valid = 1 unless the head is dropped.
  - Load data = dbus_rdata >> (8 × offset), then zero- or sign-extend to 32 bits per size and signed.
  - data_ok with an empty queue is ignored.
  - data_ok is never expected in the same cycle as the acceptance of the same request. Push and pop in the same cycle are both performed.
- Response latency: exactly 1 cycle after data_ok. resp_valid is otherwise 0 and there is no backpressure.
- Flush:
  - Clears the hold register if it is not accepted that cycle. If it is accepted in the flush cycle, it is pushed with dropped = 1.
  - Marks every queued entry dropped. Dropped entries still consume their data_ok but produce no resp_valid.
  - A pending misaligned exception response is suppressed.
  - req_ready = 0 during the flush cycle.

Test Plan:
- Word load to 0x8000_0010, addr_ok in the same cycle, data_ok 3 cycles later with rdata 0xDEAD_BEEF -> one resp_valid pulse one cycle after data_ok, resp_rdata 0xDEADBEEF, tag preserved.
- Signed byte load to 0x...03 with rdata 0x8000_0000 -> resp_rdata 0xFFFF_FF80. The same access unsigned -> 0x0000_0080.
- Store half 0x1234_ABCD to 0x...02 -> dbus_wstrb 4'b1100, dbus_wdata 0xABCD_ABCD; response has resp_rdata 0 and resp_op 1.
- addr_ok held low for 5 cycles with OUTSTANDING = 2 -> dbus fields stable throughout. After 2 acceptances without data_ok, req_ready = 0 until the first data_ok.
- Load word to 0x...06 -> no dbus_valid; resp_exc = 1 the cycle after acceptance. With one load outstanding, the misaligned op waits (req_ready = 0) until that load's response.
- Two loads outstanding, flush asserted, then 2 data_ok pulses -> no resp_valid, queue empty afterwards. A new load issued after flush returns normally.
